// File: rtl/tt_bist_pkg.sv
// Shared types, default constants and the MISR step function for the BIST harness.
package tt_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST_DUT,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [15:0] DEF_LFSR_POLY = 16'hB400;
  localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;
  localparam logic [31:0] DEF_MISR_POLY = 32'h04C11DB7;

  // Widest signature the step function supports; narrower MISRs are zero-extended.
  localparam int unsigned MISR_MAX_W = 64;

  // One MISR update for a register of 'width' bits held in the low bits of a
  // MISR_MAX_W vector: shift left, fold the outgoing MSB through poly, xor obs.
  function automatic logic [MISR_MAX_W-1:0] misr_step(
    input logic [MISR_MAX_W-1:0] sig,
    input logic [MISR_MAX_W-1:0] obs_ext,
    input logic [MISR_MAX_W-1:0] poly,
    input int unsigned           width
  );
    logic [MISR_MAX_W-1:0] mask;
    logic [MISR_MAX_W-1:0] msb_vec;
    logic [MISR_MAX_W-1:0] fb;
    mask    = {MISR_MAX_W{1'b1}} >> (MISR_MAX_W - width);
    msb_vec = sig >> (width - 1);
    fb      = msb_vec[0] ? poly : '0;
    return ((sig << 1) ^ fb ^ obs_ext) & mask;
  endfunction

endpackage

// File: rtl/tt_bist_lfsr.sv
// Galois LFSR with synchronous seed load and step enable; a zero seed becomes 1.
module tt_bist_lfsr #(
  parameter int unsigned   W    = 16,
  parameter logic [W-1:0]  POLY = 16'hB400,
  parameter logic [W-1:0]  SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         load,
  input  logic         en,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] SEED_EFF = (SEED == '0) ? W'(1) : SEED;

  // Load has priority over stepping so a reset or new run always restarts the sequence.
  always_ff @(posedge clk) begin
    if (load) begin
      q <= SEED_EFF;
    end else if (en) begin
      q <= (q >> 1) ^ (q[0] ? POLY : '0);
    end
  end

endmodule

// File: rtl/tt_bist_harness.sv
// Self-test harness: LFSR stimulus into a wrapped user design, MISR compaction
// of its outputs, and a pass/fail compare against a golden signature.
module tt_bist_harness
  import tt_bist_pkg::*;
#(
  parameter int unsigned          IN_W       = 8,
  parameter int unsigned          OUT_W      = 8,
  parameter int unsigned          N_CH       = 3,
  parameter int unsigned          SIG_W      = 32,
  parameter logic [2*IN_W-1:0]    LFSR_POLY  = DEF_LFSR_POLY,
  parameter logic [2*IN_W-1:0]    LFSR_SEED  = DEF_LFSR_SEED,
  parameter logic [SIG_W-1:0]     MISR_POLY  = DEF_MISR_POLY,
  parameter int unsigned          RST_CYCLES = 4,
  parameter int unsigned          CYCLES     = 256,
  parameter int unsigned          LAT        = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [SIG_W-1:0]        expected_sig,
  input  logic [N_CH*OUT_W-1:0]   obs,
  output logic [IN_W-1:0]         stim_ui,
  output logic [IN_W-1:0]         stim_uio,
  output logic                    dut_rst_n,
  output logic                    dut_ena,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [SIG_W-1:0]        signature
);

  localparam int unsigned OBS_W = N_CH * OUT_W;

  if (SIG_W < OBS_W || SIG_W > MISR_MAX_W) begin : g_bad_sig_w
    $error("tt_bist_harness: SIG_W must cover N_CH*OUT_W and not exceed MISR_MAX_W");
  end

  localparam logic [31:0] RST_LAST   = 32'(RST_CYCLES - 1);
  localparam logic [31:0] RUN_LAST   = 32'(CYCLES - 1);
  localparam logic [31:0] DRAIN_LAST = 32'((LAT > 0) ? LAT - 1 : 0);
  localparam logic [31:0] LAT_V      = 32'(LAT);
  // When latency exceeds the run length the leading DRAIN cycles are skipped,
  // keeping the update count at exactly CYCLES.
  localparam logic [31:0] DRAIN_SKIP = 32'((LAT > CYCLES) ? LAT - CYCLES : 0);
  localparam bit          HAS_DRAIN  = (LAT > 0);

  state_t                  state;
  logic [31:0]             cnt;
  logic [2*IN_W-1:0]       lfsr_q;
  logic                    start_ok;
  logic                    lfsr_load;
  logic                    lfsr_en;
  logic                    misr_en;
  logic [MISR_MAX_W-1:0]   sig_ext;
  logic [MISR_MAX_W-1:0]   obs_ext;
  logic [MISR_MAX_W-1:0]   poly_ext;
  logic [MISR_MAX_W-1:0]   step_ext;
  logic [SIG_W-1:0]        sig_next;

  // Sequence control: seed on reset or accepted start, step whenever the next cycle is RUN.
  always_comb begin
    start_ok  = start && (state == IDLE || state == DONE);
    lfsr_load = rst || start_ok;
    lfsr_en   = (state == RST_DUT && cnt == RST_LAST) ||
                (state == RUN && cnt != RUN_LAST);
    misr_en   = (state == RUN   && (cnt + 32'd1) > LAT_V) ||
                (state == DRAIN && (cnt + 32'd1) > DRAIN_SKIP);
  end

  tt_bist_lfsr #(
    .W    (2 * IN_W),
    .POLY (LFSR_POLY),
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .load (lfsr_load),
    .en   (lfsr_en),
    .q    (lfsr_q)
  );

  // Next MISR value; equals the current signature when compaction is idle.
  always_comb begin
    sig_ext                = '0;
    sig_ext[SIG_W-1:0]     = signature;
    obs_ext                = '0;
    obs_ext[OBS_W-1:0]     = obs;
    poly_ext               = '0;
    poly_ext[SIG_W-1:0]    = MISR_POLY;
    step_ext               = misr_step(sig_ext, obs_ext, poly_ext, SIG_W);
    sig_next               = misr_en ? step_ext[SIG_W-1:0] : signature;
  end

  // Run FSM with registered DUT controls, stimulus, status and signature.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      stim_ui   <= '0;
      stim_uio  <= '0;
      dut_rst_n <= 1'b0;
      dut_ena   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      signature <= '0;
    end else begin
      case (state)
        IDLE: begin
          dut_rst_n <= 1'b1;
          dut_ena   <= 1'b0;
          stim_ui   <= '0;
          stim_uio  <= '0;
          if (start) begin
            state     <= RST_DUT;
            cnt       <= '0;
            busy      <= 1'b1;
            dut_rst_n <= 1'b0;
            signature <= '0;
          end
        end
        RST_DUT: begin
          signature <= '0;
          if (cnt == RST_LAST) begin
            state     <= RUN;
            cnt       <= '0;
            dut_rst_n <= 1'b1;
            dut_ena   <= 1'b1;
            stim_ui   <= lfsr_q[IN_W-1:0];
            stim_uio  <= lfsr_q[2*IN_W-1:IN_W];
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        RUN: begin
          signature <= sig_next;
          if (cnt == RUN_LAST) begin
            cnt      <= '0;
            stim_ui  <= '0;
            stim_uio <= '0;
            if (HAS_DRAIN) begin
              state <= DRAIN;
            end else begin
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              dut_ena <= 1'b0;
              pass    <= (sig_next == expected_sig);
            end
          end else begin
            cnt      <= cnt + 32'd1;
            stim_ui  <= lfsr_q[IN_W-1:0];
            stim_uio <= lfsr_q[2*IN_W-1:IN_W];
          end
        end
        DRAIN: begin
          signature <= sig_next;
          if (cnt == DRAIN_LAST) begin
            state   <= DONE;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            dut_ena <= 1'b0;
            pass    <= (sig_next == expected_sig);
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        DONE: begin
          if (start) begin
            state     <= RST_DUT;
            cnt       <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            dut_rst_n <= 1'b0;
            signature <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_bist_harness.sv
// Directed bench for tt_bist_harness: three configurations, scoreboarded run results.
module tb_tt_bist_harness;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_mis = 0;

  // ---------------- default configuration ----------------
  logic        start_d, rst_n_d, ena_d, busy_d, done_d, pass_d;
  logic [31:0] exp_d, sig_d;
  logic [23:0] obs_d, obs_reg;
  logic [7:0]  ui_d, uio_d;
  logic        obs_mode;

  // Stand-in user design with one cycle of latency.
  always @(posedge clk) obs_reg <= {8'(ui_d + uio_d), uio_d, ui_d};
  assign obs_d = obs_mode ? obs_reg : 24'h0;

  tt_bist_harness u_d (
    .clk(clk), .rst(rst), .start(start_d), .expected_sig(exp_d), .obs(obs_d),
    .stim_ui(ui_d), .stim_uio(uio_d), .dut_rst_n(rst_n_d), .dut_ena(ena_d),
    .busy(busy_d), .done(done_d), .pass(pass_d), .signature(sig_d)
  );

  // ---------------- CYCLES=2, LAT=0 ----------------
  logic        start_c2, rst_n_c2, ena_c2, busy_c2, done_c2, pass_c2;
  logic [31:0] exp_c2, sig_c2;
  logic [23:0] obs_c2;
  logic [7:0]  ui_c2, uio_c2;

  tt_bist_harness #(.CYCLES(2), .LAT(0)) u_c2 (
    .clk(clk), .rst(rst), .start(start_c2), .expected_sig(exp_c2), .obs(obs_c2),
    .stim_ui(ui_c2), .stim_uio(uio_c2), .dut_rst_n(rst_n_c2), .dut_ena(ena_c2),
    .busy(busy_c2), .done(done_c2), .pass(pass_c2), .signature(sig_c2)
  );

  // ---------------- CYCLES=1, LAT=2 ----------------
  logic        start_c1, rst_n_c1, ena_c1, busy_c1, done_c1, pass_c1;
  logic [31:0] exp_c1, sig_c1;
  logic [23:0] obs_c1;
  logic [7:0]  ui_c1, uio_c1;

  tt_bist_harness #(.CYCLES(1), .LAT(2)) u_c1 (
    .clk(clk), .rst(rst), .start(start_c1), .expected_sig(exp_c1), .obs(obs_c1),
    .stim_ui(ui_c1), .stim_uio(uio_c1), .dut_rst_n(rst_n_c1), .dut_ena(ena_c1),
    .busy(busy_c1), .done(done_c1), .pass(pass_c1), .signature(sig_c1)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    string       tag;
    int          unit;
    logic [31:0] sig;
    logic        pass;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   start_cyc[3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic done_of(input int u);
    case (u)
      0:       return done_d;
      1:       return done_c2;
      default: return done_c1;
    endcase
  endfunction

  function automatic logic [31:0] sig_of(input int u);
    case (u)
      0:       return sig_d;
      1:       return sig_c2;
      default: return sig_c1;
    endcase
  endfunction

  function automatic logic pass_of(input int u);
    case (u)
      0:       return pass_d;
      1:       return pass_c2;
      default: return pass_c1;
    endcase
  endfunction

  // Reference signature for the default run fed by the stand-in design.
  function automatic logic [31:0] model_sig();
    logic [15:0] s = 16'hACE1;
    logic [31:0] m = 32'h0;
    logic [23:0] o;
    for (int i = 0; i < 256; i++) begin
      o = {8'(s[7:0] + s[15:8]), s[15:8], s[7:0]};
      m = {m[30:0], 1'b0} ^ (m[31] ? 32'h04C11DB7 : 32'h0) ^ {8'h0, o};
      s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    end
    return m;
  endfunction

  task automatic start_run(input int u, input string tag, input logic [31:0] sig,
                           input logic pass, input int lat);
    exp_t e;
    e.tag = tag; e.unit = u; e.sig = sig; e.pass = pass; e.lat = lat;
    sb.push_back(e);
    case (u)
      0:       start_d  = 1'b1;
      1:       start_c2 = 1'b1;
      default: start_c1 = 1'b1;
    endcase
    tick();
    start_d = 1'b0; start_c2 = 1'b0; start_c1 = 1'b0;
    start_cyc[u] = cyc;
  endtask

  task automatic wait_done(input int u);
    exp_t e;
    logic seen;
    e    = sb.pop_front();
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (done_of(u)) seen = 1'b1;
      else tick();
    end
    check({e.tag, "_done"}, 32'(seen), 32'd1);
    check({e.tag, "_latency"}, 32'(cyc - start_cyc[u]), 32'(e.lat));
    check({e.tag, "_sig"}, sig_of(u), e.sig);
    check({e.tag, "_pass"}, 32'(pass_of(u)), 32'(e.pass));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] golden;
    golden   = model_sig();
    rst      = 1'b1;
    start_d  = 1'b0; start_c2 = 1'b0; start_c1 = 1'b0;
    exp_d    = '0;   exp_c2   = '0;   exp_c1   = '0;
    obs_c2   = '0;   obs_c1   = '0;
    obs_mode = 1'b0;

    repeat (3) tick();
    check("rst_busy",  32'(busy_d), 32'd0);
    check("rst_done",  32'(done_d), 32'd0);
    check("rst_pass",  32'(pass_d), 32'd0);
    check("rst_sig",   sig_d, 32'd0);
    check("rst_rst_n", 32'(rst_n_d), 32'd0);
    check("rst_ena",   32'(ena_d), 32'd0);
    check("rst_stim",  32'({uio_d, ui_d}), 32'd0);
    check("rst_busy_c2", 32'(busy_c2), 32'd0);

    rst = 1'b0;
    tick();
    check("idle_rst_n", 32'(rst_n_d), 32'd1);
    while (cyc < 10) tick();

    // Run A: quiet outputs, golden 0.
    start_run(0, "runA", 32'h0, 1'b1, 261);
    check("runA_busy",   32'(busy_d), 32'd1);
    check("runA_rst_n0", 32'(rst_n_d), 32'd0);
    repeat (3) tick();
    check("runA_rst_n3", 32'(rst_n_d), 32'd0);
    tick();
    check("runA_rst_n_run", 32'(rst_n_d), 32'd1);
    check("runA_ena",       32'(ena_d), 32'd1);
    check("stim_run0",      32'({uio_d, ui_d}), 32'h0000ACE1);
    tick();
    check("stim_run1",      32'({uio_d, ui_d}), 32'h0000E270);
    repeat (98) tick();
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    check("busy_start_ignored", 32'(busy_d), 32'd1);
    wait_done(0);

    // Signature must not move in DONE even with live outputs.
    obs_mode = 1'b1;
    repeat (3) tick();
    check("done_frozen_sig", sig_d, 32'h0);
    check("done_sticky",     32'(done_d), 32'd1);

    // Start from DONE clears status and begins a run, which is then aborted.
    exp_d   = golden;
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    check("restart_done", 32'(done_d), 32'd0);
    check("restart_pass", 32'(pass_d), 32'd0);
    check("restart_busy", 32'(busy_d), 32'd1);
    repeat (4 + 50) tick();
    rst = 1'b1;
    tick();
    check("abort_busy",  32'(busy_d), 32'd0);
    check("abort_sig",   sig_d, 32'h0);
    check("abort_done",  32'(done_d), 32'd0);
    check("abort_rst_n", 32'(rst_n_d), 32'd0);
    check("abort_stim",  32'({uio_d, ui_d}), 32'd0);
    tick();
    check("abort_rst_n_held", 32'(rst_n_d), 32'd0);
    rst = 1'b0;
    tick();
    check("abort_idle_rst_n", 32'(rst_n_d), 32'd1);

    // Run B: full run with the stand-in design feeding the MISR.
    start_run(0, "runB", golden, 1'b1, 261);
    wait_done(0);

    // Two-cycle run without drain.
    obs_c2 = 24'h000001;
    exp_c2 = 32'h3;
    start_run(1, "c2_pass", 32'h3, 1'b1, 6);
    wait_done(1);
    exp_c2 = 32'h4;
    start_run(1, "c2_fail", 32'h3, 1'b0, 6);
    wait_done(1);

    // Single-cycle run where the only update happens in the last drain cycle.
    exp_c1 = 32'h1;
    start_run(2, "c1_drain", 32'h1, 1'b1, 7);
    repeat (6) tick();
    obs_c1 = 24'h000001;
    wait_done(2);
    obs_c1 = 24'h0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
